// File: rtl/agc_histogram.sv
// agc_histogram: per-window 32-bin histogram of the 8-lane 5-bit AGC code stream.
// Optional feature macro AGC_HIST_CLIP_EN adds clip_count_o (samples at +15 or -16).
module agc_histogram #(
    parameter int NCLOCKS    = 131072,
    parameter int COUNT_BITS = 21
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [59:0]           dat_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [4:0]            rd_addr_i,
`ifdef AGC_HIST_CLIP_EN
    output logic [COUNT_BITS-1:0] clip_count_o,
`endif
    output logic [COUNT_BITS-1:0] rd_dat_o
);

    // state | meaning
    // IDLE  | bins hold last window, waiting for start_i
    // RUN   | NCLOCKS cycles of dat_i qualified into the pipeline
    // FLUSH | 2 cycles draining stages 2/3 before done_o
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int WW = $clog2(NCLOCKS);
    localparam logic [WW-1:0] WIN_LAST = WW'(NCLOCKS - 1);

    state_t                  state_q, state_d;
    logic [WW-1:0]           win_cnt_q;
    logic                    flush_cnt_q;
    logic                    clear_bins;
    logic                    done_d;

    logic                    v1_q, v2_q;
    logic [59:0]             dat1_q;
    logic [3:0]              lane_cnt [32];
    logic [3:0]              cnt2_q   [32];
    logic [COUNT_BITS-1:0]   bins_q   [32];

    function automatic logic [COUNT_BITS-1:0] sat_add(input logic [COUNT_BITS-1:0] a,
                                                      input logic [3:0] b);
        logic [COUNT_BITS:0] s;
        s = {1'b0, a} + (COUNT_BITS+1)'(b);
        return s[COUNT_BITS] ? '1 : s[COUNT_BITS-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        clear_bins = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    clear_bins = 1'b1;
                end
            end
            RUN: begin
                if (win_cnt_q == WIN_LAST)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_o      <= (state_d != IDLE);
            done_o      <= done_d;
            flush_cnt_q <= (state_q == FLUSH) ? ~flush_cnt_q : 1'b0;
            if (clear_bins)
                win_cnt_q <= '0;
            else if (state_q == RUN)
                win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    // Stage 2 combinational: how many of the 8 lanes land in each bin.
    always_comb begin
        for (int b = 0; b < 32; b++) begin
            lane_cnt[b] = '0;
            for (int i = 0; i < 8; i++)
                lane_cnt[b] = lane_cnt[b] + {3'b000, (dat1_q[5*i +: 5] == 5'(b))};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            dat1_q <= '0;
            for (int b = 0; b < 32; b++)
                cnt2_q[b] <= '0;
        end else begin
            v1_q   <= (state_q == RUN);
            dat1_q <= dat_i;
            v2_q   <= v1_q;
            for (int b = 0; b < 32; b++)
                cnt2_q[b] <= lane_cnt[b];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int b = 0; b < 32; b++)
                bins_q[b] <= '0;
        end else if (clear_bins) begin
            for (int b = 0; b < 32; b++)
                bins_q[b] <= '0;
        end else if (v2_q) begin
            for (int b = 0; b < 32; b++)
                bins_q[b] <= sat_add(bins_q[b], cnt2_q[b]);
        end
    end

`ifdef AGC_HIST_CLIP_EN
    // Bins 15 (+15) and 16 (-16) together never exceed 8 lanes, so 4 bits suffice.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            clip_count_o <= '0;
        else if (clear_bins)
            clip_count_o <= '0;
        else if (v2_q)
            clip_count_o <= sat_add(clip_count_o, 4'(cnt2_q[15] + cnt2_q[16]));
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rd_dat_o <= '0;
        else
            rd_dat_o <= bins_q[rd_addr_i];
    end

endmodule

// File: tb/tb_agc_histogram.sv
// tb_agc_histogram: scoreboard bench for agc_histogram with a 16-cycle window.
// Expected bins are queued while a window is driven and popped on readout.
module tb_agc_histogram;
    localparam int N  = 16;
    localparam int CB = 21;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start_i = 1'b0;
    logic [59:0]   dat_i = '0;
    logic [4:0]    rd_addr_i = '0;
    logic          busy_o, done_o;
    logic [CB-1:0] rd_dat_o;
`ifdef AGC_HIST_CLIP_EN
    logic [CB-1:0] clip_count_o;
    int            clip_q[$];
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 aclk = ~aclk;

    agc_histogram #(.NCLOCKS(N), .COUNT_BITS(CB)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .dat_i(dat_i),
        .start_i(start_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .rd_addr_i(rd_addr_i),
`ifdef AGC_HIST_CLIP_EN
        .clip_count_o(clip_count_o),
`endif
        .rd_dat_o(rd_dat_o)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Pulse start, then drive nfeed counted cycles; expected bins go to exp_q.
    task automatic feed(input int mode, input int nfeed, input bit mid);
        int hist[32];
        int clip;
        logic [4:0] c;
        clip = 0;
        for (int b = 0; b < 32; b++) hist[b] = 0;
        exp_q.delete();
        dat_i   = 60'({$urandom(), $urandom()});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: busy_o=%b expected 1", busy_o);
        end
        for (int k = 1; k <= nfeed; k++) begin
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0: c = 5'h03;
                    1: c = 5'(i);
                    3: c = (i % 4 == 0) ? 5'h0F : (i % 4 == 1) ? 5'h10 : 5'h00;
                    default: c = 5'($urandom_range(31, 0));
                endcase
                dat_i[5*i +: 5] = c;
                hist[c]++;
                if (c == 5'h0F || c == 5'h10) clip++;
            end
            start_i = mid && (k == 5 || k == 10);
            tick();
            start_i = 1'b0;
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_run k=%0d: busy_o=%b expected 1", k, busy_o);
            end
        end
        dat_i = 60'({$urandom(), $urandom()});
        for (int b = 0; b < 32; b++) exp_q.push_back(hist[b]);
`ifdef AGC_HIST_CLIP_EN
        clip_q.push_back(clip);
`endif
    endtask

    // Entered at cycle N+1; done_o must appear at cycle N+3.
    task automatic wait_done(input bit mid);
        int t;
        bit seen;
        t = N + 1;
        seen = 1'b0;
        while (t < N + 12 && !seen) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_flush t=%0d: busy_o=%b expected 1", t, busy_o);
                end
                start_i = mid && (t == N + 1);
                tick();
                start_i = 1'b0;
                t++;
            end
        end
        checks++;
        if (!seen || t != N + 3) begin
            errors++;
            $display("FAIL done_cycle: seen=%b at cycle %0d expected cycle %0d", seen, t, N + 3);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_done: busy_o=%b expected 0", busy_o);
        end
`ifdef AGC_HIST_CLIP_EN
        if (clip_q.size() > 0) begin
            int e;
            e = clip_q.pop_front();
            checks++;
            if (clip_count_o !== CB'(e)) begin
                errors++;
                $display("FAIL clip_count: got %0d expected %0d", clip_count_o, e);
            end
        end
`endif
    endtask

    task automatic readout(input int exp_sum);
        int sum;
        int e;
        sum = 0;
        for (int a = 0; a < 32; a++) begin
            rd_addr_i = 5'(a);
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (rd_dat_o !== CB'(e)) begin
                errors++;
                $display("FAIL bin[%0d]: got %0d expected %0d", a, rd_dat_o, e);
            end
            sum += int'(rd_dat_o);
            if (a == 0) begin
                checks++;
                if (done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: done_o=%b expected 0", done_o);
                end
            end
        end
        checks++;
        if (sum != exp_sum) begin
            errors++;
            $display("FAIL bin_sum: got %0d expected %0d", sum, exp_sum);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_dat_o !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b rd=%0d expected 0/0/0", busy_o, done_o, rd_dat_o);
        end
        aresetn = 1'b1;
        tick();
        exp_q.delete();
        for (int b = 0; b < 32; b++) exp_q.push_back(0);
        readout(0);
    endtask

    task automatic test_constant();
        feed(0, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask

    task automatic test_lanes();
        feed(1, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask

    task automatic test_random();
        feed(2, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask

    task automatic test_mid_start();
        feed(1, N, 1'b1);
        wait_done(1'b1);
        readout(8 * N);
    endtask

    task automatic test_back_to_back();
        feed(2, N, 1'b0);
        wait_done(1'b0);
        feed(0, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        feed(2, 7, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b expected 0/0", busy_o, done_o);
        end
        #1;
        aresetn = 1'b1;
`ifdef AGC_HIST_CLIP_EN
        clip_q.delete();
`endif
        saw_done = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            tick();
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: done_o seen=1 expected 0");
        end
        exp_q.delete();
        for (int b = 0; b < 32; b++) exp_q.push_back(0);
        readout(0);
        feed(0, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask

`ifdef AGC_HIST_CLIP_EN
    task automatic test_clip();
        feed(3, N, 1'b0);
        wait_done(1'b0);
        readout(8 * N);
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_lanes();
        test_random();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
`ifdef AGC_HIST_CLIP_EN
        test_clip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
